booth_multiplier: RTL and testbench

Sequential radix-2 Booth multiplier. It forms the 8-bit two's-complement product of an 8-bit multiplicand and a 4-bit signed multiplier over four clocked steps. Step sequencing is driven externally through a 3-bit step index `count`, so the block sits under a controller or counter that owns the timing. The module is named `booth_multiplier`. The product is registered and reads out on `result_out`.

---
 rtl/booth_multiplier.sv | 57 +++++
 tb/tb_booth_multiplier.sv | 123 ++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential radix-2 Booth multiplier, 8-bit M x 4-bit signed Q -> 8-bit product over four externally sequenced steps
//   clk          rising-edge clock
//   reset        asynchronous active-low reset; clears accumulator and latched operands
//   result_out   accumulator (partial sums between steps, product after step 3)
//   multiplicand 8-bit two's-complement M, sampled at step 0
//   multiplier   4-bit two's-complement Q, sampled at step 0
//   count        step index: 0..3 perform Booth step, 4..7 hold
module booth_multiplier (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] result_out,
    input  logic [7:0] multiplicand,
    input  logic [3:0] multiplier,
    input  logic [2:0] count
);
    logic [7:0] acc_q, acc_d;
    logic [7:0] m_q, m_d;
    logic [3:0] q_q, q_d;
    logic       start;
    logic [1:0] idx;
    logic [7:0] m_use;
    logic [3:0] q_use;
    logic [4:0] q_ext;
    logic [1:0] pair;
    logic [7:0] base;
    logic [7:0] m_sh;
    always_comb begin
        start = count == 3'd0;
        idx   = count[1:0];
        // step 0 works straight from the ports so a product can start without a load cycle
        m_use = start ? multiplicand : m_q;
        q_use = start ? multiplier : q_q;
        // appending q_{-1} = 0 lets every step read its pair (q_i, q_{i-1}) as two adjacent bits
        q_ext = {q_use, 1'b0} >> idx;
        pair  = q_ext[1:0];
        base  = start ? 8'h00 : acc_q;
        m_sh  = m_use << idx;
        acc_d = acc_q;
        m_d   = start ? multiplicand : m_q;
        q_d   = start ? multiplier : q_q;
        if (!count[2])
            acc_d = pair == 2'b01 ? base + m_sh :
                    pair == 2'b10 ? base - m_sh : base;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= 8'h00;
            m_q   <= 8'h00;
            q_q   <= 4'h0;
        end else begin
            acc_q <= acc_d;
            m_q   <= m_d;
            q_q   <= q_d;
        end
    end
    assign result_out = acc_q;
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: scoreboard bench for booth_multiplier with directed, hand-computed vectors
module tb_booth_multiplier;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] result_out;
    logic [7:0] multiplicand = 8'h00;
    logic [3:0] multiplier = 4'h0;
    logic [2:0] count = 3'd7;
    int errors = 0;
    int checks = 0;
    typedef struct {
        logic [7:0] exp;
        int         tag;
    } exp_t;
    exp_t sb[$];
    booth_multiplier dut (
        .clk(clk),
        .reset(reset),
        .result_out(result_out),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .count(count)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (result_out !== e.exp) begin
                errors++;
                $display("FAIL step%0d: result_out=%h expected=%h", e.tag, result_out, e.exp);
            end
        end
    end
    int tag = 0;
    task automatic step(input logic [2:0] c, input logic [7:0] m, input logic [3:0] q, input logic [7:0] exp);
        exp_t e;
        @(negedge clk);
        count = c;
        multiplicand = m;
        multiplier = q;
        e.exp = exp;
        e.tag = tag++;
        sb.push_back(e);
    endtask
    task automatic direct(input string name, input logic [7:0] exp);
        checks++;
        if (result_out !== exp) begin
            errors++;
            $display("FAIL %s: result_out=%h expected=%h", name, result_out, exp);
        end
    endtask
    initial begin
        #2;
        direct("reset_state", 8'h00);
        @(negedge clk);
        reset = 1'b1;
        // basic 5 x 7, then hold through count 4..7
        step(0, 8'h05, 4'b0111, 8'hFB);
        step(1, 8'h05, 4'b0111, 8'hFB);
        step(2, 8'h05, 4'b0111, 8'hFB);
        step(3, 8'h05, 4'b0111, 8'h23);
        for (int c = 4; c < 8; c++) step(3'(c), 8'h05, 4'b0111, 8'h23);
        // 6 x -3, -8 x 16, zero multiplier, wrap-around cases; 3 -> 0 back to back
        step(0, 8'h06, 4'b1101, 8'hFA);
        step(1, 8'h06, 4'b1101, 8'h06);
        step(2, 8'h06, 4'b1101, 8'hEE);
        step(3, 8'h06, 4'b1101, 8'hEE);
        step(0, 8'h10, 4'b1000, 8'h00);
        step(1, 8'h10, 4'b1000, 8'h00);
        step(2, 8'h10, 4'b1000, 8'h00);
        step(3, 8'h10, 4'b1000, 8'h80);
        step(0, 8'h10, 4'b0000, 8'h00);
        step(1, 8'h10, 4'b0000, 8'h00);
        step(2, 8'h10, 4'b0000, 8'h00);
        step(3, 8'h10, 4'b0000, 8'h00);
        step(0, 8'h7F, 4'b0111, 8'h81);
        step(1, 8'h7F, 4'b0111, 8'h81);
        step(2, 8'h7F, 4'b0111, 8'h81);
        step(3, 8'h7F, 4'b0111, 8'h79);
        step(0, 8'hFF, 4'b0111, 8'h01);
        step(1, 8'hFF, 4'b0111, 8'h01);
        step(2, 8'hFF, 4'b0111, 8'h01);
        step(3, 8'hFF, 4'b0111, 8'hF9);
        // operands change after step 0 must be ignored
        step(0, 8'h05, 4'b0111, 8'hFB);
        step(1, 8'hAA, 4'b0001, 8'hFB);
        step(2, 8'hAA, 4'b0001, 8'hFB);
        step(3, 8'hAA, 4'b0001, 8'h23);
        step(4, 8'hAA, 4'b0001, 8'h23);
        // reset between steps 2 and 3
        step(0, 8'h03, 4'b0011, 8'hFD);
        step(1, 8'h03, 4'b0011, 8'hFD);
        step(2, 8'h03, 4'b0011, 8'h09);
        @(negedge clk);
        count = 3'd7;
        reset = 1'b0;
        #1;
        direct("async_reset", 8'h00);
        @(posedge clk);
        #1;
        direct("reset_held", 8'h00);
        @(negedge clk);
        reset = 1'b1;
        step(0, 8'h03, 4'b0011, 8'hFD);
        step(1, 8'h03, 4'b0011, 8'hFD);
        step(2, 8'h03, 4'b0011, 8'h09);
        step(3, 8'h03, 4'b0011, 8'h09);
        step(7, 8'h03, 4'b0011, 8'h09);
        @(negedge clk);
        count = 3'd7;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
